dtree_vote_filter: RTL and testbench



---
 rtl/dtree_pkg.sv | 22 ++
 rtl/dtree_vote_hist.sv | 91 +++++++++
 rtl/dtree_vote_filter.sv | 126 ++++++++++++
 tb/tb_dtree_vote_filter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dtree_pkg
//  Brief    : Shared types and defaults for the decision-tree vote filter.
//  Revision : 1.0  initial release
// ============================================================================
package dtree_pkg;

    // Width of the class code produced by the upstream decision tree
    localparam int DEF_CLASS_W = 4;

    typedef logic [DEF_CLASS_W-1:0] class_t;

    // Control FSM of the vote filter
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dtree_vote_hist.sv
`default_nettype none
// ============================================================================
//  Module   : dtree_vote_hist
//  Brief    : Sliding-window histogram: circular buffer of the last WINDOW
//             class codes plus one occurrence counter per class, with a
//             single read port into the counter array.
//  Revision : 1.0  initial release
// ============================================================================
module dtree_vote_hist #(
    parameter int CLASS_W = 4,
    parameter int WINDOW  = 8,
    parameter int CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic [CLASS_W-1:0] i_class,
    input  logic [CLASS_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]   o_rd_cnt,
    output logic [CNT_W-1:0]   o_fill
);

    localparam int NUM_CLASSES = 2 ** CLASS_W;
    localparam int PTR_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [CLASS_W-1:0] r_buf [WINDOW];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_cnt [NUM_CLASSES];

    logic               w_full;
    logic [CLASS_W-1:0] w_evict_cls;

    // Once the window is full the slot about to be overwritten holds the
    // oldest sample, which is the one leaving the vote.
    assign w_full      = (r_fill == CNT_W'(WINDOW));
    assign w_evict_cls = r_buf[r_wr_ptr];

    // Sample storage; contents past fill are never read, so no reset needed
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_buf[r_wr_ptr] <= i_class;
        end
    end

    // Write pointer wraps at WINDOW-1; fill saturates at WINDOW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(WINDOW - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
            logic w_inc;
            logic w_dec;

            assign w_inc = i_push && (i_class == CLASS_W'(k));
            assign w_dec = i_push && w_full && (w_evict_cls == CLASS_W'(k));

            // Per-class counter; an eviction of the same class as the new
            // sample cancels out and leaves the count unchanged
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[k] <= '0;
                end else if (i_clear) begin
                    r_cnt[k] <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (w_dec && !w_inc) begin
                    r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end
        end
    endgenerate

    assign o_rd_cnt = r_cnt[i_rd_idx];
    assign o_fill   = r_fill;

endmodule
`default_nettype wire

// File: rtl/dtree_vote_filter.sv
`default_nettype none
// ============================================================================
//  Module   : dtree_vote_filter
//  Brief    : Temporal majority-vote filter for the decision-tree classifier.
//             Accepts one class per handshake, scans the window histogram one
//             class per cycle and presents the majority class and its count.
//  Revision : 1.0  initial release
// ============================================================================
module dtree_vote_filter
    import dtree_pkg::*;
#(
    parameter  int CLASS_W = DEF_CLASS_W,
    parameter  int WINDOW  = 8,
    localparam int CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [CLASS_W-1:0] in_class,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CLASS_W-1:0] out_class,
    output logic [CNT_W-1:0]   out_votes,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   fill
);

    localparam int NUM_CLASSES = 2 ** CLASS_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CLASS_W-1:0] r_idx;
    logic [CLASS_W-1:0] r_best_cls;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [CLASS_W-1:0] r_out_class;
    logic [CNT_W-1:0]   r_out_votes;

    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic               w_take;
    logic [CLASS_W-1:0] w_new_cls;
    logic [CNT_W-1:0]   w_new_cnt;

    // clear blocks acceptance so a flush never lets a sample slip in
    assign w_accept = (r_state == ST_IDLE) && in_valid && !clear;
    assign w_last   = (r_idx == CLASS_W'(NUM_CLASSES - 1));

    // Strict greater-than keeps the lowest index on ties
    assign w_take    = (w_rd_cnt > r_best_cnt);
    assign w_new_cls = w_take ? r_idx : r_best_cls;
    assign w_new_cnt = w_take ? w_rd_cnt : r_best_cnt;

    dtree_vote_hist #(
        .CLASS_W (CLASS_W),
        .WINDOW  (WINDOW),
        .CNT_W   (CNT_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (clear),
        .i_push   (w_accept),
        .i_class  (in_class),
        .i_rd_idx (r_idx),
        .o_rd_cnt (w_rd_cnt),
        .o_fill   (fill)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Scan index, running best and the registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_best_cls  <= '0;
            r_best_cnt  <= '0;
            r_out_class <= '0;
            r_out_votes <= '0;
        end else if (clear) begin
            r_idx      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
        end else if (w_accept) begin
            r_idx      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
        end else if (r_state == ST_SCAN) begin
            r_idx      <= r_idx + 1'b1;
            r_best_cls <= w_new_cls;
            r_best_cnt <= w_new_cnt;
            if (w_last) begin
                r_out_class <= w_new_cls;
                r_out_votes <= w_new_cnt;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign out_class = r_out_class;
    assign out_votes = r_out_votes;

endmodule
`default_nettype wire

// File: tb/tb_dtree_vote_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtree_vote_filter
//  Brief    : Self-checking bench for dtree_vote_filter against a queue-based
//             majority-vote reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dtree_vote_filter;

    localparam int CLASS_W     = 4;
    localparam int WINDOW      = 8;
    localparam int CNT_W       = $clog2(WINDOW + 1);
    localparam int NUM_CLASSES = 2 ** CLASS_W;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic [CLASS_W-1:0] in_class;
    logic               in_ready;
    logic               out_valid;
    logic [CLASS_W-1:0] out_class;
    logic [CNT_W-1:0]   out_votes;
    logic               out_ready;
    logic [CNT_W-1:0]   fill;

    int checks   = 0;
    int failures = 0;

    // Reference window: oldest sample at the front
    int model_q[$];

    dtree_vote_filter #(
        .CLASS_W (CLASS_W),
        .WINDOW  (WINDOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_class  (in_class),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_class (out_class),
        .out_votes (out_votes),
        .out_ready (out_ready),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Majority over the reference window, lowest class wins ties
    function automatic int model_class();
        int cnt [NUM_CLASSES];
        int best_c = 0;
        int best_n = 0;
        foreach (cnt[k]) cnt[k] = 0;
        foreach (model_q[i]) cnt[model_q[i]]++;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt[k] > best_n) begin
                best_n = cnt[k];
                best_c = k;
            end
        end
        return best_c;
    endfunction

    function automatic int model_votes();
        int n = 0;
        int c = model_class();
        foreach (model_q[i]) if (model_q[i] == c) n++;
        return n;
    endfunction

    task automatic model_push(input int c);
        model_q.push_back(c);
        if (model_q.size() > WINDOW) void'(model_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one edge (DUT is expected to be in IDLE)
    task automatic accept(input int c);
        in_valid = 1'b1;
        in_class = CLASS_W'(c);
        check_value("in_ready_idle", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        model_push(c);
    endtask

    // Wait for the result, check latency and content
    task automatic wait_result();
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check_value("latency", n, NUM_CLASSES);
        check_value("out_class", int'(out_class), model_class());
        check_value("out_votes", int'(out_votes), model_votes());
        check_value("fill", int'(fill), model_q.size());
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_value("out_valid_drop", int'(out_valid), 0);
    endtask

    task automatic send(input int c);
        accept(c);
        wait_result();
        handshake();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_q.delete();
    endtask

    int seen;
    int stable;
    int hold_cls;
    int hold_votes;

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_class  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        check_value("rst_in_ready", int'(in_ready), 0);
        check_value("rst_out_valid", int'(out_valid), 0);
        check_value("rst_out_class", int'(out_class), 0);
        check_value("rst_out_votes", int'(out_votes), 0);
        check_value("rst_fill", int'(fill), 0);
        rst = 1'b0;
        step();

        // Single sample
        send(5);
        check_value("single_class", int'(out_class), 5);
        check_value("single_votes", int'(out_votes), 1);

        // Window fill, then an eviction that flips the majority
        do_clear();
        begin
            int seq [8] = '{3, 3, 7, 7, 7, 3, 3, 1};
            foreach (seq[i]) send(seq[i]);
        end
        check_value("fill_class", int'(out_class), 3);
        check_value("fill_votes", int'(out_votes), 4);
        send(7);
        check_value("evict_class", int'(out_class), 7);
        check_value("evict_votes", int'(out_votes), 4);

        // Tie-break to the lowest index
        do_clear();
        repeat (4) begin
            send(9);
            send(2);
        end
        check_value("tie_class", int'(out_class), 2);
        check_value("tie_votes", int'(out_votes), 4);

        // Backpressure: result holds, new input is refused
        accept(11);
        wait_result();
        hold_cls   = int'(out_class);
        hold_votes = int'(out_votes);
        in_valid   = 1'b1;
        in_class   = 4'd1;
        stable     = 1;
        repeat (20) begin
            step();
            if (!out_valid || in_ready || int'(out_class) != hold_cls ||
                int'(out_votes) != hold_votes || int'(fill) != model_q.size())
                stable = 0;
        end
        check_value("bp_stable", stable, 1);
        in_valid = 1'b0;
        handshake();

        // Eviction of the same class
        do_clear();
        repeat (8) send(4);
        send(4);
        check_value("same_evict_votes", int'(out_votes), 8);
        check_value("same_evict_fill", int'(fill), 8);

        // clear mid-SCAN with in_valid high
        accept(5);
        repeat (5) step();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_class = 4'd9;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        check_value("clr_fill", int'(fill), 0);
        check_value("clr_in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1;
        end
        check_value("clr_no_valid", seen, 0);
        send(6);
        check_value("clr_next_class", int'(out_class), 6);
        check_value("clr_next_votes", int'(out_votes), 1);

        // rst pulsed mid-SCAN: asynchronous return to reset values
        accept(5);
        repeat (5) step();
        rst = 1'b1;
        #2;
        check_value("arst_in_ready", int'(in_ready), 0);
        check_value("arst_fill", int'(fill), 0);
        check_value("arst_out_class", int'(out_class), 0);
        model_q.delete();
        step();
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1;
        end
        check_value("arst_no_valid", seen, 0);
        send(6);
        check_value("arst_next_class", int'(out_class), 6);
        check_value("arst_next_votes", int'(out_votes), 1);

        // Randomized traffic with a small class alphabet to force ties
        do_clear();
        repeat (60) begin
            int c;
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_CLASSES - 1)
                                            : $urandom_range(0, 3) * 3;
            accept(c);
            wait_result();
            repeat ($urandom_range(0, 3)) step();
            handshake();
            if ($urandom_range(0, 29) == 0) do_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
